iport_irq: RTL

- Z80 I/O-space responder that is the input-side counterpart of the output port.
- Samples 8 external input pins through a synchroniser and captures programmable edges into a sticky status register.
- Raises an active-low maskable interrupt to the CPU and returns an IM2 vector byte during interrupt acknowledge.
- Sits behind the address decoder and system bus mux. Decoder supplies `ena`; read data returns on the slave bus.

---
 rtl/z80_iport_pkg.sv | 21 ++
 rtl/pin_sync.sv | 63 ++++++
 rtl/iport_irq.sv | 100 ++++++++++
 3 files changed

// File: rtl/z80_iport_pkg.sv
// rtl/z80_iport_pkg.sv - shared bus types and register map for the input port
package z80_iport_pkg;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  dmaster;
    logic        inta;
  } Z80MasterBus;

  typedef struct packed {
    logic [7:0] dslave;
  } Z80SlaveBus;

  localparam logic [1:0] IPORT_DATA   = 2'd0;
  localparam logic [1:0] IPORT_STATUS = 2'd1;
  localparam logic [1:0] IPORT_MASK   = 2'd2;
  localparam logic [1:0] IPORT_CTRL   = 2'd3;

  localparam logic [7:0] IPORT_IDLE_DATA = 8'hFF;

endpackage

// File: rtl/pin_sync.sv
// rtl/pin_sync.sv - one-bit synchroniser, optional debouncer (IPORT_DEBOUNCE_EN), edge pulses
module pin_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
  end

  assign synced = sync_q[SYNC_STAGES-1];

`ifdef IPORT_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [CW-1:0] deb_cnt;
  logic          deb_q;

  // Level only follows the synced input after DEB_CYCLES consecutive disagreeing clks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_cnt <= '0;
      deb_q   <= 1'b0;
    end else if (synced != deb_q) begin
      if (deb_cnt == CW'(DEB_CYCLES - 1)) begin
        deb_q   <= synced;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end else begin
      deb_cnt <= '0;
    end
  end

  assign level = deb_q;
`else
  localparam int unused_deb_cycles = DEB_CYCLES;

  assign level = synced;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev_q <= 1'b0;
    else          prev_q <= level;
  end

  assign rise = level & ~prev_q;
  assign fall = ~level & prev_q;

endmodule

// File: rtl/iport_irq.sv
// rtl/iport_irq.sv - Z80 input port with edge-capture status, IM2 interrupt; debounce via IPORT_DEBOUNCE_EN
module iport_irq
  import z80_iport_pkg::*;
#(
  parameter int         SYNC_STAGES  = 2,
  parameter logic [7:0] RESET_VECTOR = 8'hF0,
  parameter int         DEB_CYCLES   = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ena,
  input  logic        iord,
  input  logic        iowr,
  input  Z80MasterBus ibus,
  output Z80SlaveBus  obus,
  input  logic [7:0]  pins,
  output logic        int_n
);

  logic [7:0] pin_level;
  logic [7:0] pin_rise;
  logic [7:0] pin_fall;
  logic [7:0] edges;
  logic [7:0] status_q;
  logic [7:0] mask_q;
  logic [7:0] ctrl_q;
  logic [7:0] clr;
  logic [7:0] rd_data;
  logic [7:0] dslave_q;
  logic       int_n_q;
  logic       wr_req;
  logic       wr_seen_q;
  logic       wr_fire;
  logic       unused_addr;

  assign unused_addr = ^ibus.addr[15:2];

  for (genvar i = 0; i < 8; i++) begin : g_pin
    pin_sync #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEB_CYCLES (DEB_CYCLES)
    ) u_pin_sync (
      .clk    (clk),
      .reset_n(reset_n),
      .pin    (pins[i]),
      .level  (pin_level[i]),
      .rise   (pin_rise[i]),
      .fall   (pin_fall[i])
    );
  end

  assign edges = ctrl_q[0] ? pin_fall : pin_rise;

  // wr_seen resets high so a strobe already held at reset release is ignored.
  assign wr_req  = ena & iowr;
  assign wr_fire = wr_req & ~wr_seen_q;
  assign clr     = (wr_fire && ibus.addr[1:0] == IPORT_STATUS) ? ibus.dmaster : 8'h00;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_seen_q <= 1'b1;
      status_q  <= 8'h00;
      mask_q    <= 8'h00;
      ctrl_q    <= RESET_VECTOR & 8'hFE;
    end else begin
      wr_seen_q <= wr_req;
      status_q  <= (status_q & ~clr) | edges;
      if (wr_fire && ibus.addr[1:0] == IPORT_MASK) mask_q <= ibus.dmaster;
      if (wr_fire && ibus.addr[1:0] == IPORT_CTRL) ctrl_q <= ibus.dmaster;
    end
  end

  always_comb begin
    rd_data = IPORT_IDLE_DATA;
    case (ibus.addr[1:0])
      IPORT_DATA:   rd_data = pin_level;
      IPORT_STATUS: rd_data = status_q;
      IPORT_MASK:   rd_data = mask_q;
      IPORT_CTRL:   rd_data = ctrl_q;
      default:      rd_data = IPORT_IDLE_DATA;
    endcase
  end

  // Acknowledge outranks a register read and does not depend on ena.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dslave_q <= IPORT_IDLE_DATA;
      int_n_q  <= 1'b1;
    end else begin
      if (ibus.inta)       dslave_q <= {ctrl_q[7:1], 1'b0};
      else if (ena & iord) dslave_q <= rd_data;
      else                 dslave_q <= IPORT_IDLE_DATA;
      int_n_q <= ~|(status_q & mask_q);
    end
  end

  assign obus.dslave = dslave_q;
  assign int_n       = int_n_q;

endmodule
